regfile_access_sched: RTL

//  Sequences and arbitrates accesses to a column of regfileSlice bit-slices. Two requesters

---
 rtl/regfile_access_sched_if.sv | 36 +++
 rtl/regfile_access_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_sched_if.sv
// Request/grant bundle between the L and R requesters and the regfile access scheduler,
// together with the slice control lines the scheduler drives.
interface regfile_access_sched_if #(
   parameter int NREGS = 14,
   parameter int IDX_W = 4
);
   logic             l_req;
   logic [IDX_W-1:0] l_idx;
   logic             l_we;
   logic             l_gnt;
   logic             l_rvalid;

   logic             r_req;
   logic [IDX_W-1:0] r_idx;
   logic             r_we;
   logic             r_gnt;
   logic             r_rvalid;

   logic             swap_af;
   logic             swap_exx;

   logic [NREGS-1:0] regsel;
   logic             pc_wr;
   logic             reg_wr;
   logic             r_p;

   modport master (
      output l_req, l_idx, l_we, r_req, r_idx, r_we, swap_af, swap_exx,
      input  l_gnt, l_rvalid, r_gnt, r_rvalid, regsel, pc_wr, reg_wr, r_p
   );

   modport slave (
      input  l_req, l_idx, l_we, r_req, r_idx, r_we, swap_af, swap_exx,
      output l_gnt, l_rvalid, r_gnt, r_rvalid, regsel, pc_wr, reg_wr, r_p
   );
endinterface

// File: rtl/regfile_access_sched.sv
// Arbitrates L (PC-side) and R (data-side) accesses onto a column of regfile slices.
// Define REGFILE_BANK_SWAP_EN to enable AF/EXX bank swapping of logical register indices.
module regfile_access_sched #(
   parameter int NREGS    = 14,
   parameter int IDX_W    = 4,
   parameter int TURN_CYC = 1
) (
   input logic                   eclk_i,
   input logic                   erst_n_i,
   regfile_access_sched_if.slave bus
);

   localparam logic [1:0]       S_IDLE    = 2'd0;
   localparam logic [1:0]       S_SPLIT   = 2'd1;
   localparam logic [1:0]       S_JOIN    = 2'd2;
   localparam logic [1:0]       S_TURN    = 2'd3;
   localparam logic [IDX_W:0]   NREGS_X   = (IDX_W+1)'(NREGS);
   localparam logic [1:0]       TURN_LAST = 2'(TURN_CYC - 1);

   function automatic logic [NREGS-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NREGS-1:0] v;
      v = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (idx == IDX_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic in_file(input logic [IDX_W-1:0] idx);
      return {1'b0, idx} < NREGS_X;
   endfunction

   // AF/AF' live at 12/13, the EXX-swapped pairs at 6..11; a set bank bit flips the pair LSB.
   function automatic logic [IDX_W-1:0] phys_idx(input logic [IDX_W-1:0] idx,
                                                 input logic baf, input logic bexx);
      logic [IDX_W-1:0] p;
      p = idx;
      if (idx == IDX_W'(12) || idx == IDX_W'(13)) begin
         p[0] = idx[0] ^ baf;
      end else if (idx >= IDX_W'(6) && idx <= IDX_W'(11)) begin
         p[0] = idx[0] ^ bexx;
      end
      return p;
   endfunction

   logic bank_af;
   logic bank_exx;

`ifdef REGFILE_BANK_SWAP_EN
   logic bank_af_q;
   logic bank_exx_q;

   always_ff @(posedge eclk_i or negedge erst_n_i) begin
      if (!erst_n_i) begin
         bank_af_q  <= 1'b0;
         bank_exx_q <= 1'b0;
      end else begin
         if (bus.swap_af)  bank_af_q  <= ~bank_af_q;
         if (bus.swap_exx) bank_exx_q <= ~bank_exx_q;
      end
   end

   assign bank_af  = bank_af_q;
   assign bank_exx = bank_exx_q;
`else
   logic unused_swap;
   assign unused_swap = bus.swap_af ^ bus.swap_exx;
   assign bank_af     = 1'b0;
   assign bank_exx    = 1'b0;
`endif

   logic [1:0]       state_q, state_d;
   logic [1:0]       turn_q, turn_d;
   logic             rr_q, rr_d;
   logic             l_gnt_q, l_gnt_d;
   logic             r_gnt_q, r_gnt_d;
   logic             l_rd_q, l_rd_d;
   logic             r_rd_q, r_rd_d;
   logic             l_rvalid_q, l_rvalid_d;
   logic             r_rvalid_q, r_rvalid_d;
   logic [NREGS-1:0] regsel_q, regsel_d;
   logic             pc_wr_q, pc_wr_d;
   logic             reg_wr_q, reg_wr_d;
   logic             r_p_q, r_p_d;

   logic [IDX_W-1:0] l_pidx, r_pidx;
   logic             l_nat, r_nat;
   logic             l_pend, r_pend;
   logic             win_l;
   logic             grant_l, grant_r;

   // A requester still shows its old req during its own grant cycle, so that cycle is masked.
   always_comb begin
      l_pidx = phys_idx(bus.l_idx, bank_af, bank_exx);
      r_pidx = phys_idx(bus.r_idx, bank_af, bank_exx);
      l_nat  = l_pidx < IDX_W'(2);
      r_nat  = (r_pidx >= IDX_W'(2)) && in_file(r_pidx);
      l_pend = bus.l_req && !l_gnt_q;
      r_pend = bus.r_req && !r_gnt_q;
      win_l  = l_pend && (!r_pend || !rr_q);
   end

   always_comb begin
      state_d    = state_q;
      turn_d     = turn_q;
      rr_d       = rr_q;
      grant_l    = 1'b0;
      grant_r    = 1'b0;
      l_gnt_d    = 1'b0;
      r_gnt_d    = 1'b0;
      l_rd_d     = 1'b0;
      r_rd_d     = 1'b0;
      regsel_d   = '0;
      pc_wr_d    = 1'b0;
      reg_wr_d   = 1'b0;
      r_p_d      = 1'b0;
      l_rvalid_d = l_gnt_q && l_rd_q;
      r_rvalid_d = r_gnt_q && r_rd_q;

      case (state_q)
         S_IDLE, S_SPLIT: begin
            state_d = S_IDLE;
            if (l_pend && r_pend && l_nat && r_nat) begin
               state_d = S_SPLIT;
               grant_l = 1'b1;
               grant_r = 1'b1;
            end else if (l_pend && !r_pend && l_nat) begin
               state_d = S_SPLIT;
               grant_l = 1'b1;
            end else if (r_pend && !l_pend && r_nat) begin
               state_d = S_SPLIT;
               grant_r = 1'b1;
            end else if (l_pend || r_pend) begin
               state_d = S_JOIN;
               grant_l = win_l;
               grant_r = !win_l;
               r_p_d   = 1'b1;
            end
         end
         S_JOIN: begin
            state_d = S_TURN;
            turn_d  = TURN_LAST;
            r_p_d   = 1'b1;
         end
         default: begin
            // Bus stays joined with every select low until the turnaround count expires.
            if (turn_q != 2'd0) begin
               turn_d = turn_q - 2'd1;
               r_p_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase

      if (grant_l) begin
         l_gnt_d  = 1'b1;
         l_rd_d   = !bus.l_we;
         regsel_d = regsel_d | onehot(l_pidx);
         pc_wr_d  = bus.l_we && in_file(l_pidx);
      end
      if (grant_r) begin
         r_gnt_d  = 1'b1;
         r_rd_d   = !bus.r_we;
         regsel_d = regsel_d | onehot(r_pidx);
         reg_wr_d = bus.r_we && in_file(r_pidx);
      end
      if ((grant_l && !rr_q) || (grant_r && rr_q)) begin
         rr_d = !rr_q;
      end
   end

   always_ff @(posedge eclk_i or negedge erst_n_i) begin
      if (!erst_n_i) begin
         state_q    <= S_IDLE;
         turn_q     <= 2'd0;
         rr_q       <= 1'b0;
         l_gnt_q    <= 1'b0;
         r_gnt_q    <= 1'b0;
         l_rd_q     <= 1'b0;
         r_rd_q     <= 1'b0;
         l_rvalid_q <= 1'b0;
         r_rvalid_q <= 1'b0;
         regsel_q   <= '0;
         pc_wr_q    <= 1'b0;
         reg_wr_q   <= 1'b0;
         r_p_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         turn_q     <= turn_d;
         rr_q       <= rr_d;
         l_gnt_q    <= l_gnt_d;
         r_gnt_q    <= r_gnt_d;
         l_rd_q     <= l_rd_d;
         r_rd_q     <= r_rd_d;
         l_rvalid_q <= l_rvalid_d;
         r_rvalid_q <= r_rvalid_d;
         regsel_q   <= regsel_d;
         pc_wr_q    <= pc_wr_d;
         reg_wr_q   <= reg_wr_d;
         r_p_q      <= r_p_d;
      end
   end

   assign bus.l_gnt    = l_gnt_q;
   assign bus.r_gnt    = r_gnt_q;
   assign bus.l_rvalid = l_rvalid_q;
   assign bus.r_rvalid = r_rvalid_q;
   assign bus.regsel   = regsel_q;
   assign bus.pc_wr    = pc_wr_q;
   assign bus.reg_wr   = reg_wr_q;
   assign bus.r_p      = r_p_q;

endmodule
